// File: rtl/alu_issue_queue.sv
// alu_issue_queue: FIFO-buffered issue stage feeding the ALU with a registered valid/ready result
module alu_issue_queue #(
  parameter int DEPTH  = 4,
  parameter int INST_W = 10,
  parameter int DATA_W = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [INST_W-1:0]        in_inst,
  output logic                     in_ready,
  input  logic                     flush,
  output logic [INST_W-1:0]        alu_inst,
  input  logic [DATA_W-1:0]        alu_out,
  output logic                     res_valid,
  input  logic                     res_ready,
  output logic [DATA_W-1:0]        res_data,
  output logic [1:0]               res_op,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     busy
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  typedef enum logic [1:0] {IDLE, EXEC, HOLD} state_t;
  state_t state, state_n;
  logic [INST_W-1:0] mem [DEPTH];
  logic [AW-1:0] rd_ptr, wr_ptr;
  logic push, pop;
  // count never exceeds DEPTH (a power of two), so its MSB alone marks "full"
  assign in_ready  = !count[AW] && !flush;
  assign push      = in_valid && in_ready;
  assign pop       = !flush && (count != '0) && (state == IDLE || (state == HOLD && res_ready));
  assign res_valid = state == HOLD;
  assign busy      = state != IDLE;
  // next state: EXEC always settles into HOLD; a pop starts EXEC; a retire with nothing queued idles
  always_comb
    state_n = flush ? IDLE : state == EXEC ? HOLD : pop ? EXEC : (state == HOLD && res_ready) ? IDLE : state;
  // queue storage needs no reset; only entries between the pointers are ever read
  always_ff @(posedge clk)
    if (push) mem[wr_ptr] <= in_inst;
  // pointers, occupancy, issued instruction and captured result
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state    <= IDLE;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      alu_inst <= '0;
      res_data <= '0;
      res_op   <= '0;
    end else begin
      state <= state_n;
      count <= flush ? '0 : count + CW'(push) - CW'(pop);
      if (flush) begin
        rd_ptr   <= '0;
        wr_ptr   <= '0;
        alu_inst <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + AW'(1);
        if (pop) begin
          rd_ptr   <= rd_ptr + AW'(1);
          alu_inst <= mem[rd_ptr];
        end
        if (state == EXEC) begin
          res_data <= alu_out;
          res_op   <= alu_inst[INST_W-1 -: 2];
        end
      end
    end
endmodule

// File: doc/alu_issue_queue.md
# alu_issue_queue

Instruction issue stage placed directly upstream of the 4-bit ALU. It buffers 10-bit ALU instructions (opcode[9:8], A[7:4], B[3:0]) from the front-end in a small FIFO and presents them one at a time on the ALU instruction bus. It captures each combinational ALU result into a registered output with a valid/ready handshake. This decouples the GUI/switch input logic from result consumers, such as the display driver and the UART reporter.

## Interface
Parameters:
- DEPTH, 4, FIFO entries; power of two, ≥ 2.
- INST_W, 10, instruction width; fixed by the ALU format.
- DATA_W, 4, ALU result width.

Ports:
- clk  in  1  Single clock; all state updates on its rising edge.
- rst  in  1  Asynchronous, active-high reset.
- in_valid  in  1  Front-end has an instruction on in_inst.
- in_inst  in  INST_W  Instruction to enqueue.
- in_ready  out  1  Queue can accept; equals (count < DEPTH) && !flush.
- flush  in  1  Synchronous clear of FIFO, pending result and FSM.
- alu_inst  out  INST_W  Registered instruction driven to the ALU inst input.
- alu_out  in  DATA_W  ALU_Out returned from the ALU, combinational on alu_inst.
- res_valid  out  1  res_data/res_op hold a result.
- res_ready  in  1  Consumer accepts the result.
- res_data  out  DATA_W  Captured ALU result.
- res_op  out  2  Opcode of the captured instruction (alu_inst[9:8] at capture).
- count  out  $clog2(DEPTH)+1  FIFO occupancy, excluding the instruction in flight.
- busy  out  1  FSM not in IDLE.

## Operation
- FIFO: circular buffer with rd_ptr/wr_ptr that wrap modulo DEPTH, plus a registered count.
  - Push when in_valid && in_ready.
  - Pop only under FSM control.
  - Simultaneous push and pop leaves count unchanged.
  - Push while full is rejected by in_ready = 0, even if a pop occurs in the same cycle.
- FSM states:
  - IDLE: if count > 0, pop head into alu_inst and go to EXEC; else stay.
  - EXEC: one settle cycle for the combinational ALU. At the edge, load res_data ← alu_out and res_op ← alu_inst[9:8], set res_valid, go to HOLD.
  - HOLD: res_valid = 1 and res_data/res_op are stable. On res_valid && res_ready:
    - if count > 0, pop the next instruction into alu_inst, clear res_valid, go to EXEC;
    - else clear res_valid, go to IDLE.
- alu_inst holds its last value in IDLE/HOLD. It changes only on a pop, a flush or rst.
- flush (highest synchronous priority):
  - count, rd_ptr and wr_ptr go to 0;
  - res_valid goes to 0;
  - state goes to IDLE;
  - any same-cycle push is dropped;
  - alu_inst goes to 0; res_data/res_op hold their values.
- The block does no arithmetic itself. Widths pass through unchanged.

## Timing
- Reset values: alu_inst = 0, res_valid = 0, res_data = 0, res_op = 0, count = 0, busy = 0, in_ready = 1, state = IDLE, pointers = 0.
- Reset mid-operation clears everything immediately (asynchronous). In-flight and queued instructions are lost.
- Latency, empty queue: push accepted at edge T → alu_inst valid after T+1 → res_valid = 1 after T+2.
- Throughput with res_ready held high and the queue non-empty: one result per 2 cycles (HOLD→EXEC→HOLD).
- While res_ready = 0, res_data, res_op and alu_inst are stable. The queue keeps accepting until count = DEPTH.
- in_ready reflects the registered count only, with no combinational path from res_ready.
- Capacity: DEPTH queued plus 1 in flight. With res_ready = 0, DEPTH+1 instructions are accepted before in_ready falls.

## Test plan
- Reset then push 10'b00_0011_0101 → res_valid high 2 cycles after accept; res_data = 4'b1000, res_op = 2'b00.
- Back-to-back pushes of 01_0010_0101, 10_1010_0101, 11_0001_0000 with res_ready = 1 → results 4'b1101, 4'b1111, 4'b1111 in order, spaced 2 cycles apart, with res_op 01, 10, 11.
- res_ready = 0, push continuously (DEPTH = 4) → 5 accepts, then in_ready = 0 and count = 4. Releasing res_ready drains all 5 results in push order, and pointers wrap correctly on a second fill.
- Hold res_ready = 0 for 10 cycles with a result pending → res_data, res_op and alu_inst are unchanged throughout. A single res_ready pulse retires exactly one result.
- flush asserted with count = 3 and res_valid = 1, with in_valid = 1 in the same cycle → next cycle count = 0, res_valid = 0, busy = 0, and the pushed instruction never appears as a result.
- Assert rst asynchronously during EXEC → all outputs take their reset values before the next clk edge. The first instruction pushed after reset completes normally.
